// File: rtl/video_mem_rd_scan.sv
// video_mem_rd_scan: sequential video memory reader and 1-bit pixel serialiser.
//
// Purpose: walks the frame from BASE_ADDR, issuing one byte read per cycle
// while the 2-entry prefetch FIFO plus reads in flight hold fewer than two
// bytes. Returned bytes are shifted out MSB first, one pixel per consume
// cycle (hactive && g_en).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   g_en              global enable; low freezes reads, FSM and shifting
//   frame_start       restart pulse; flushes buffers, clears underrun
//   hactive           pixel demand
//   video_mem_addr    read address (the address of the current read)
//   video_mem_rd_en   read strobe
//   video_mem_d_in    read data, valid RD_LAT cycles after the strobe
//   pixel             registered pixel
//   pixel_valid       pixel carries demanded data
//   underrun          sticky: demand seen with no data available
//
// Build option: define VIDEO_RD_PIXDBL_EN for horizontal pixel doubling
// (each bit is output on two consecutive consume cycles).

module video_mem_rd_scan #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          H_BYTES   = 80,
    parameter int          V_LINES   = 480,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        g_en,
    input  logic        frame_start,
    input  logic        hactive,
    output logic [15:0] video_mem_addr,
    output logic        video_mem_rd_en,
    input  logic [7:0]  video_mem_d_in,
    output logic        pixel,
    output logic        pixel_valid,
    output logic        underrun
);

    localparam logic [16:0] FRAME_BYTES = 17'(H_BYTES * V_LINES);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t            state;
    logic [16:0]       issued;
    logic [RD_LAT-1:0] dl;
    logic [1:0]        inflight;
    logic [1:0]        discard;
    logic [1:0]        fifo_cnt;
    logic [7:0]        fifo_mem [2];
    logic              fifo_wp;
    logic              fifo_rp;
    logic [7:0]        sh;
    logic [3:0]        sh_cnt;
`ifdef VIDEO_RD_PIXDBL_EN
    logic              tog;
`endif

    logic ret;
    logic fifo_wr;
    logic fifo_rd;
    logic consume;
    logic [2:0] occupancy;

    // frame_start owns its cycle: no consume and no read while flushing,
    // so nothing issued at the old address needs to be accounted for.
    assign consume   = hactive && g_en && !frame_start;
    assign ret       = dl[RD_LAT-1];
    assign occupancy = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign video_mem_rd_en = (state == FETCH) && g_en && !frame_start
                             && (occupancy < 3'd2);
    assign fifo_wr   = ret && (discard == 2'd0) && !frame_start;
    assign fifo_rd   = consume && (sh_cnt == 4'd0) && (fifo_cnt != 2'd0);

    // Address generator and frame FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            video_mem_addr <= BASE_ADDR;
            issued         <= 17'd0;
        end else if (frame_start) begin
            state          <= FETCH;
            video_mem_addr <= BASE_ADDR;
            issued         <= 17'd0;
        end else if (video_mem_rd_en) begin
            video_mem_addr <= video_mem_addr + 16'd1;
            issued         <= issued + 17'd1;
            if (issued == FRAME_BYTES - 17'd1)
                state <= DONE;
        end
    end

    // Return tracking. inflight counts every outstanding read; on a flush
    // all of them (less any landing this cycle) become stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl       <= '0;
            inflight <= 2'd0;
            discard  <= 2'd0;
        end else begin
            dl[0] <= video_mem_rd_en;
            for (int i = 1; i < RD_LAT; i++)
                dl[i] <= dl[i-1];
            inflight <= inflight + {1'b0, video_mem_rd_en} - {1'b0, ret};
            if (frame_start)
                discard <= inflight - {1'b0, ret};
            else if (ret && (discard != 2'd0))
                discard <= discard - 2'd1;
        end
    end

    // Two-entry prefetch FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= 2'd0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
        end else if (frame_start) begin
            fifo_cnt <= 2'd0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
        end else begin
            if (fifo_wr)
                fifo_wp <= ~fifo_wp;
            if (fifo_rd)
                fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_wr} - {1'b0, fifo_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem[fifo_wp] <= video_mem_d_in;
    end

    // Pixel serialiser. sh holds the not-yet-shifted bits MSB aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh          <= 8'd0;
            sh_cnt      <= 4'd0;
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
`ifdef VIDEO_RD_PIXDBL_EN
            tog         <= 1'b0;
`endif
        end else if (frame_start) begin
            sh          <= 8'd0;
            sh_cnt      <= 4'd0;
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;
`ifdef VIDEO_RD_PIXDBL_EN
            tog         <= 1'b0;
`endif
        end else if (consume) begin
            if (sh_cnt != 4'd0) begin
                pixel       <= sh[7];
                pixel_valid <= 1'b1;
`ifdef VIDEO_RD_PIXDBL_EN
                // second showing of this bit: advance
                if (tog) begin
                    sh     <= {sh[6:0], 1'b0};
                    sh_cnt <= sh_cnt - 4'd1;
                end
                tog <= ~tog;
`else
                sh     <= {sh[6:0], 1'b0};
                sh_cnt <= sh_cnt - 4'd1;
`endif
            end else if (fifo_cnt != 2'd0) begin
                pixel       <= fifo_mem[fifo_rp][7];
                pixel_valid <= 1'b1;
`ifdef VIDEO_RD_PIXDBL_EN
                // bit7 shown once already; keep it for its repeat
                sh     <= fifo_mem[fifo_rp];
                sh_cnt <= 4'd8;
                tog    <= 1'b1;
`else
                sh     <= {fifo_mem[fifo_rp][6:0], 1'b0};
                sh_cnt <= 4'd7;
`endif
            end else begin
                pixel       <= 1'b0;
                pixel_valid <= 1'b0;
                underrun    <= 1'b1;
            end
        end else begin
            pixel_valid <= 1'b0;
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(fifo_wr && !fifo_rd && (fifo_cnt == 2'd2))
    );

endmodule

// File: tb/tb_video_mem_rd_scan.sv
// tb_video_mem_rd_scan: two instances (RD_LAT 1 and 3) against a frame-level
// model: the expected pixel stream is the frame's bytes MSB first.

module tb_video_mem_rd_scan;

`ifdef VIDEO_RD_PIXDBL_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        g_en;
    logic        frame_start;
    logic        hactive;
    logic [15:0] addr  [2];
    logic        rd_en [2];
    logic [7:0]  din   [2];
    logic        pix   [2];
    logic        pv    [2];
    logic        ur    [2];

    logic [7:0]  mem [256];
    logic [7:0]  dp0;
    logic [7:0]  dp1 [3];

    int vecs = 0;
    int errs = 0;
    int bitidx [2];
    logic urm [2];
    logic [15:0] eaddr [2];
    int nreads [2];
    bit pix_chk = 1'b1;
    logic [15:0] hold [2];
    logic [15:0] cap;

    always #5 clk = ~clk;

    video_mem_rd_scan #(
        .BASE_ADDR(16'h0000), .H_BYTES(2), .V_LINES(2), .RD_LAT(1)
    ) u0 (
        .clk(clk), .rst(rst), .g_en(g_en), .frame_start(frame_start),
        .hactive(hactive), .video_mem_addr(addr[0]),
        .video_mem_rd_en(rd_en[0]), .video_mem_d_in(din[0]),
        .pixel(pix[0]), .pixel_valid(pv[0]), .underrun(ur[0])
    );

    video_mem_rd_scan #(
        .BASE_ADDR(16'h0010), .H_BYTES(4), .V_LINES(3), .RD_LAT(3)
    ) u1 (
        .clk(clk), .rst(rst), .g_en(g_en), .frame_start(frame_start),
        .hactive(hactive), .video_mem_addr(addr[1]),
        .video_mem_rd_en(rd_en[1]), .video_mem_d_in(din[1]),
        .pixel(pix[1]), .pixel_valid(pv[1]), .underrun(ur[1])
    );

    // memory read ports; non-read cycles present garbage
    always @(posedge clk)
        dp0 <= rd_en[0] ? mem[addr[0][7:0]] : 8'($urandom);
    always @(posedge clk) begin
        dp1[0] <= rd_en[1] ? mem[addr[1][7:0]] : 8'($urandom);
        dp1[1] <= dp1[0];
        dp1[2] <= dp1[1];
    end
    assign din[0] = dp0;
    assign din[1] = dp1[2];

    function automatic logic [15:0] base(input int k);
        return (k == 0) ? 16'h0000 : 16'h0010;
    endfunction

    function automatic int fb(input int k);
        return (k == 0) ? 4 : 12;
    endfunction

    function automatic int total(input int k);
        return fb(k) * 8 * REP;
    endfunction

    function automatic logic sbit(input int k, input int i);
        int b;
        logic [15:0] a;
        logic [7:0] by;
        b  = i / REP;
        a  = base(k) + 16'(b / 8);
        by = mem[a[7:0]];
        return by[7 - (b % 8)];
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s dut%0d: observed %0h expected %0h",
                   tag, k, obs, exp);
        end
    endtask

    task automatic model_idle();
        for (int k = 0; k < 2; k++) begin
            bitidx[k] = total(k);
            urm[k]    = 1'b0;
            eaddr[k]  = base(k);
            nreads[k] = fb(k);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_addr"}, k, addr[k], base(k));
            chk({tag, "_rden"}, k, rd_en[k], 1'b0);
            chk({tag, "_pix"}, k, pix[k], 1'b0);
            chk({tag, "_pv"}, k, pv[k], 1'b0);
            chk({tag, "_ur"}, k, ur[k], 1'b0);
        end
    endtask

    task automatic step(input logic h, input logic g, input logic fs);
        hactive     = h;
        g_en        = g;
        frame_start = fs;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) begin
                chk("rd_addr", k, addr[k], eaddr[k]);
                eaddr[k] = eaddr[k] + 16'd1;
                nreads[k]++;
                chk("rd_limit", k, nreads[k] <= fb(k), 1'b1);
                chk("rd_gen", k, g, 1'b1);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (fs) begin
                bitidx[k] = 0;
                urm[k]    = 1'b0;
                eaddr[k]  = base(k);
                nreads[k] = 0;
                chk("fs_pv", k, pv[k], 1'b0);
                chk("fs_ur", k, ur[k], 1'b0);
            end else if (pix_chk) begin
                if (h && g) begin
                    if (bitidx[k] < total(k)) begin
                        chk("pv", k, pv[k], 1'b1);
                        chk("pix", k, pix[k], sbit(k, bitidx[k]));
                        bitidx[k]++;
                    end else begin
                        chk("pv_end", k, pv[k], 1'b0);
                        urm[k] = 1'b1;
                    end
                end else begin
                    chk("pv_idle", k, pv[k], 1'b0);
                end
                chk("ur", k, ur[k], urm[k]);
            end
        end
    endtask

    task automatic do_reset();
        hactive     = 1'b0;
        frame_start = 1'b0;
        rst         = 1'b1;
        #1;
        chk_reset("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_idle();
    endtask

    task automatic new_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = 8'($urandom);
    endtask

    task automatic start_frame();
        step(1'b0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        g_en        = 1'b0;
        frame_start = 1'b0;
        hactive     = 1'b0;
        new_mem();
        mem[0] = 8'hA5;
        mem[1] = 8'hFF;
        mem[2] = 8'h00;
        mem[3] = 8'h3C;
        model_idle();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;

        // idle after reset: no reads, demand underruns
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // first frame, whole-frame drain and end-of-frame underrun
        start_frame();
        cap = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0);
            cap = {cap[14:0], pix[0]};
        end
        chk("first16", 0, cap, (REP == 2) ? 16'hCC33 : 16'hA5FF);
        repeat (total(1) - 16 + 3) step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("nreads", k, nreads[k], fb(k));
            chk("end_addr", k, addr[k], base(k) + 16'(fb(k)));
            chk("end_ur", k, ur[k], 1'b1);
        end
        repeat (4) step(1'b0, 1'b1, 1'b0);

        // restart with reads in flight; stale data must not appear
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        new_mem();
        start_frame();
        repeat (40 * REP) step(1'b1, 1'b1, 1'b0);

        // g_en low mid-byte: frozen address, no valid, resumes in order
        start_frame();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++)
            hold[k] = addr[k];
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++)
                chk("addr_frz", k, addr[k], hold[k]);
        end
        repeat (20) step(1'b1, 1'b1, 1'b0);

        // demand from the frame_start cycle underruns; next restart clears
        pix_chk = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("fs_dem_pv", k, pv[k], 1'b0);
            chk("fs_dem_ur", k, ur[k], 1'b1);
        end
        pix_chk = 1'b1;
        start_frame();
        repeat (10) step(1'b1, 1'b1, 1'b0);

        // reset with reads in flight, then restart
        start_frame();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        do_reset();
        new_mem();
        start_frame();
        repeat (40 * REP) step(1'b1, 1'b1, 1'b0);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            new_mem();
            start_frame();
            repeat (250 * REP)
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) != 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
